mem_handshake_ctrl: RTL and testbench



---
 rtl/mem_handshake_ctrl_pkg.sv | 34 +++
 rtl/mem_wait_counter.sv | 40 ++++
 rtl/mem_handshake_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_handshake_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_handshake_ctrl_pkg.sv
// Shared definitions for the memory handshake controller: word size,
// FSM state encodings, wait-state limits and the wait-counter load helper.
package mem_handshake_ctrl_pkg;

    localparam int MEM_WORD_SIZE   = 16;
    localparam int MAX_WAIT_STATES = 15;
    localparam int WAIT_CNT_W      = 4;
    localparam int STAT_W          = 16;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT       = 3'd1;
    localparam logic [2:0] ST_ACCESS     = 3'd2;
    localparam logic [2:0] ST_RD_CAPTURE = 3'd3;
    localparam logic [2:0] ST_RD_DONE    = 3'd4;
    localparam logic [2:0] ST_WR_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_WAIT       = ST_WAIT,
        S_ACCESS     = ST_ACCESS,
        S_RD_CAPTURE = ST_RD_CAPTURE,
        S_RD_DONE    = ST_RD_DONE,
        S_WR_DONE    = ST_WR_DONE
    } state_e;

    // The counter counts down to zero inclusively, so N wait states load N-1.
    function automatic logic [WAIT_CNT_W-1:0] wait_load_value(input int wait_states);
        if (wait_states > 0) begin
            return WAIT_CNT_W'(wait_states - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag. Used by the handshake controller
// to insert wait states; intended for reuse by cache-fill sequencing.
module mem_wait_counter
    import mem_handshake_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_value,
    input  logic                  dec,
    output logic                  zero
);

    logic [WAIT_CNT_W-1:0] count_q;
    logic [WAIT_CNT_W-1:0] count_d;

    // Next count: load wins over decrement; decrement saturates at zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Memory-side handshake stage for the 16-bit blocking datapath. Converts the
// level readM/writeM handshake into single-cycle strobes on a synchronous
// single-port SRAM, with a programmable number of wait states.
// Optional build macro MEM_STATS_EN adds rd_count/wr_count strobe counters.
module mem_handshake_ctrl
    import mem_handshake_ctrl_pkg::*;
#(
    parameter int WORD_SIZE   = MEM_WORD_SIZE,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    output logic                 ackOutput,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [WORD_SIZE-1:0] sram_addr,
    output logic [WORD_SIZE-1:0] sram_wdata,
    input  logic [WORD_SIZE-1:0] sram_rdata
`ifdef MEM_STATS_EN
    ,
    output logic [STAT_W-1:0]    rd_count,
    output logic [STAT_W-1:0]    wr_count
`endif
);

    // The wait counter is only WAIT_CNT_W bits wide.
    generate
        if ((WAIT_STATES < 0) || (WAIT_STATES > MAX_WAIT_STATES)) begin : g_bad_wait_states
            $error("mem_handshake_ctrl: WAIT_STATES must be within 0..15");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]  rd_buf_q, rd_buf_d;
    logic                  is_write_q, is_write_d;
    logic                  sram_en_q, sram_en_d;
    logic                  sram_we_q, sram_we_d;
    logic                  input_ready_q, input_ready_d;
    logic                  ack_q, ack_d;

    logic                  wait_load;
    logic                  wait_dec;
    logic                  wait_zero;

    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (wait_load),
        .load_value (wait_load_value(WAIT_STATES)),
        .dec        (wait_dec),
        .zero       (wait_zero)
    );

    // Next-state and registered-output logic of the handshake FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_buf_d   = rd_buf_q;
        is_write_d = is_write_q;
        wait_load  = 1'b0;
        wait_dec   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Reads take priority; a simultaneous write waits for a later IDLE visit.
                if (readM) begin
                    addr_d     = address;
                    is_write_d = 1'b0;
                    wait_load  = 1'b1;
                    state_d    = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end else if (writeM) begin
                    addr_d     = address;
                    wdata_d    = data;
                    is_write_d = 1'b1;
                    wait_load  = 1'b1;
                    state_d    = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_zero) begin
                    state_d = S_ACCESS;
                end else begin
                    wait_dec = 1'b1;
                end
            end
            S_ACCESS: begin
                state_d = is_write_q ? S_WR_DONE : S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                rd_buf_d = sram_rdata;
                state_d  = S_RD_DONE;
            end
            S_RD_DONE: begin
                if (!readM) begin
                    state_d = S_IDLE;
                end
            end
            S_WR_DONE: begin
                if (!writeM) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are glitch-free flops.
        sram_en_d     = (state_d == S_ACCESS);
        sram_we_d     = (state_d == S_ACCESS) && is_write_d;
        input_ready_d = (state_d == S_RD_DONE);
        ack_d         = (state_d == S_WR_DONE);
    end

    // FSM state, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_buf_q      <= '0;
            is_write_q    <= 1'b0;
            sram_en_q     <= 1'b0;
            sram_we_q     <= 1'b0;
            input_ready_q <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_buf_q      <= rd_buf_d;
            is_write_q    <= is_write_d;
            sram_en_q     <= sram_en_d;
            sram_we_q     <= sram_we_d;
            input_ready_q <= input_ready_d;
            ack_q         <= ack_d;
        end
    end

    assign inputReady = input_ready_q;
    assign ackOutput  = ack_q;
    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    // The bus is driven only while read data is presented (RD_DONE).
    assign data = input_ready_q ? rd_buf_q : {WORD_SIZE{1'bz}};

`ifdef MEM_STATS_EN
    logic [STAT_W-1:0] rd_count_q, rd_count_d;
    logic [STAT_W-1:0] wr_count_q, wr_count_d;

    // Count SRAM strobes by type; both counters wrap naturally.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (sram_en_q) begin
            if (sram_we_q) begin
                wr_count_d = wr_count_q + 1'b1;
            end else begin
                rd_count_d = rd_count_q + 1'b1;
            end
        end
    end

    // Strobe counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Directed bench for mem_handshake_ctrl: one instance with 2 wait states,
// one with 0 wait states, each backed by a small synchronous SRAM model.
module tb_mem_handshake_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Instance A: WAIT_STATES = 2
    logic        readM, writeM;
    logic [15:0] address;
    logic [15:0] dp_data;
    logic        dp_drive;
    wire  [15:0] data;
    logic        inputReady, ackOutput, sram_en, sram_we;
    logic [15:0] sram_addr, sram_wdata, sram_rdata;

    // Instance B: WAIT_STATES = 0
    logic        readM_b, writeM_b;
    logic [15:0] address_b;
    logic [15:0] dp_data_b;
    logic        dp_drive_b;
    wire  [15:0] data_b;
    logic        inputReady_b, ackOutput_b, sram_en_b, sram_we_b;
    logic [15:0] sram_addr_b, sram_wdata_b, sram_rdata_b;

`ifdef MEM_STATS_EN
    logic [15:0] rd_count, wr_count, rd_count_b, wr_count_b;
`endif

    assign data   = dp_drive   ? dp_data   : 16'hzzzz;
    assign data_b = dp_drive_b ? dp_data_b : 16'hzzzz;

    mem_handshake_ctrl #(.WORD_SIZE(16), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .readM(readM), .writeM(writeM), .address(address),
        .data(data), .inputReady(inputReady), .ackOutput(ackOutput),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef MEM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    mem_handshake_ctrl #(.WORD_SIZE(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .readM(readM_b), .writeM(writeM_b), .address(address_b),
        .data(data_b), .inputReady(inputReady_b), .ackOutput(ackOutput_b),
        .sram_en(sram_en_b), .sram_we(sram_we_b), .sram_addr(sram_addr_b),
        .sram_wdata(sram_wdata_b), .sram_rdata(sram_rdata_b)
`ifdef MEM_STATS_EN
        , .rd_count(rd_count_b), .wr_count(wr_count_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models with a preload port and strobe counters
    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_val;
    int          en_cnt = 0;
    int          we_cnt = 0;
    int          en_cnt_b = 0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem_a[pre_addr] <= pre_val;
            mem_b[pre_addr] <= pre_val;
        end else begin
            if (sram_en) begin
                en_cnt <= en_cnt + 1;
                if (sram_we) begin
                    mem_a[sram_addr[7:0]] <= sram_wdata;
                    we_cnt <= we_cnt + 1;
                end else begin
                    sram_rdata <= mem_a[sram_addr[7:0]];
                end
            end
            if (sram_en_b) begin
                en_cnt_b <= en_cnt_b + 1;
                if (sram_we_b) mem_b[sram_addr_b[7:0]] <= sram_wdata_b;
                else           sram_rdata_b <= mem_b[sram_addr_b[7:0]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] v);
        pre_addr = a;
        pre_val  = v;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    // Read on instance A; returns data, cycles to inputReady, and a timeout flag.
    task automatic do_read(input logic [15:0] a, input logic [15:0] post_data,
                           output logic [15:0] rdata, output int lat, output bit to);
        to = 1'b0;
        lat = 0;
        address = a;
        dp_drive = 1'b0;
        readM = 1'b1;
        do begin
            tick();
            lat++;
        end while (!inputReady && lat < 40);
        if (!inputReady) to = 1'b1;
        rdata = data;
        readM = 1'b0;
        for (int i = 0; i < 40 && inputReady; i++) tick();
        if (inputReady) to = 1'b1;
        dp_data = post_data;
        dp_drive = 1'b1;
    endtask

    // Write on instance A; returns cycles to ackOutput and a timeout flag.
    task automatic do_write(input logic [15:0] a, input logic [15:0] v,
                            output int lat, output bit to);
        to = 1'b0;
        lat = 0;
        address = a;
        dp_data = v;
        dp_drive = 1'b1;
        writeM = 1'b1;
        do begin
            tick();
            lat++;
        end while (!ackOutput && lat < 40);
        if (!ackOutput) to = 1'b1;
        writeM = 1'b0;
        for (int i = 0; i < 40 && ackOutput; i++) tick();
        if (ackOutput) to = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dp_data = 16'h1234;
        dp_drive = 1'b1;
        tick();
        checks++; if (inputReady !== 1'b0) begin errors++; $display("FAIL reset_inputReady got %h want 0", inputReady); end
        checks++; if (ackOutput !== 1'b0) begin errors++; $display("FAIL reset_ackOutput got %h want 0", ackOutput); end
        checks++; if (sram_en !== 1'b0 || sram_we !== 1'b0) begin errors++; $display("FAIL reset_sram_strobe got en=%h we=%h want 0/0", sram_en, sram_we); end
        checks++; if (sram_addr !== 16'h0 || sram_wdata !== 16'h0) begin errors++; $display("FAIL reset_sram_bus got addr=%h wdata=%h want 0/0", sram_addr, sram_wdata); end
        checks++; if (data !== 16'h1234) begin errors++; $display("FAIL reset_data_released got %h want 1234", data); end
        reset = 1'b0;
        tick();
        tick();
        checks++; if (inputReady !== 1'b0 || sram_en !== 1'b0) begin errors++; $display("FAIL idle_quiet got ir=%h en=%h want 0/0", inputReady, sram_en); end
    endtask

    task automatic test_read();
        int en0;
        en0 = en_cnt;
        address = 16'h0005;
        dp_drive = 1'b0;
        readM = 1'b1;                       // cycle 0
        tick(); tick();                     // cycle 2
        checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL rd_no_early_strobe got %h want 0", sram_en); end
        tick();                             // cycle 3
        checks++; if (sram_en !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 16'h0005) begin
            errors++; $display("FAIL rd_strobe got en=%h we=%h addr=%h want 1/0/0005", sram_en, sram_we, sram_addr); end
        tick();                             // cycle 4
        checks++; if (sram_en !== 1'b0 || inputReady !== 1'b0) begin errors++; $display("FAIL rd_cycle4 got en=%h ir=%h want 0/0", sram_en, inputReady); end
        tick();                             // cycle 5
        checks++; if (inputReady !== 1'b1 || data !== 16'h7A12) begin errors++; $display("FAIL rd_ready got ir=%h data=%h want 1/7a12", inputReady, data); end
        address = 16'h00FF;                 // ignored after acceptance
        tick();                             // cycle 6
        checks++; if (inputReady !== 1'b1 || data !== 16'h7A12) begin errors++; $display("FAIL rd_hold got ir=%h data=%h want 1/7a12", inputReady, data); end
        readM = 1'b0;
        checks++; if (inputReady !== 1'b1) begin errors++; $display("FAIL rd_drop_same_cycle got %h want 1", inputReady); end
        tick();                             // cycle 7
        checks++; if (inputReady !== 1'b0) begin errors++; $display("FAIL rd_release got ir=%h want 0", inputReady); end
        dp_data = 16'h0F0F;
        dp_drive = 1'b1;
        #1;
        checks++; if (data !== 16'h0F0F) begin errors++; $display("FAIL rd_bus_released got %h want 0f0f", data); end
        checks++; if (en_cnt - en0 !== 1) begin errors++; $display("FAIL rd_strobe_count got %0d want 1", en_cnt - en0); end
    endtask

    task automatic test_write();
        int en0, we0, lat;
        bit to;
        logic [15:0] rd;
        en0 = en_cnt;
        we0 = we_cnt;
        address = 16'h0010;
        dp_data = 16'hBEEF;
        dp_drive = 1'b1;
        writeM = 1'b1;                      // cycle 0
        tick();                             // cycle 1
        address = 16'h0011;                 // later changes must be ignored
        dp_data = 16'h1111;
        tick(); tick();                     // cycle 3
        checks++; if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 16'h0010 || sram_wdata !== 16'hBEEF) begin
            errors++; $display("FAIL wr_strobe got en=%h we=%h addr=%h wdata=%h want 1/1/0010/beef", sram_en, sram_we, sram_addr, sram_wdata); end
        checks++; if (ackOutput !== 1'b0) begin errors++; $display("FAIL wr_ack_early got %h want 0", ackOutput); end
        tick();                             // cycle 4
        checks++; if (ackOutput !== 1'b1 || sram_en !== 1'b0) begin errors++; $display("FAIL wr_ack got ack=%h en=%h want 1/0", ackOutput, sram_en); end
        tick();                             // cycle 5
        writeM = 1'b0;
        tick();                             // cycle 6
        checks++; if (ackOutput !== 1'b0) begin errors++; $display("FAIL wr_ack_release got %h want 0", ackOutput); end
        checks++; if (mem_a[8'h10] !== 16'hBEEF || mem_a[8'h11] !== 16'h0000) begin
            errors++; $display("FAIL wr_mem got [10]=%h [11]=%h want beef/0000", mem_a[8'h10], mem_a[8'h11]); end
        checks++; if (en_cnt - en0 !== 1 || we_cnt - we0 !== 1) begin
            errors++; $display("FAIL wr_strobe_count got en=%0d we=%0d want 1/1", en_cnt - en0, we_cnt - we0); end
        do_read(16'h0010, 16'h0000, rd, lat, to);
        checks++; if (to || rd !== 16'hBEEF || lat != 5) begin
            errors++; $display("FAIL wr_readback got data=%h lat=%0d to=%0d want beef/5/0", rd, lat, to); end
    endtask

    task automatic test_read_priority();
        int we0, lat;
        we0 = we_cnt;
        address = 16'h0003;
        dp_drive = 1'b0;
        readM = 1'b1;
        writeM = 1'b1;
        lat = 0;
        do begin tick(); lat++; end while (!inputReady && lat < 40);
        checks++; if (inputReady !== 1'b1 || data !== 16'h0333 || lat != 5) begin
            errors++; $display("FAIL prio_read got ir=%h data=%h lat=%0d want 1/0333/5", inputReady, data, lat); end
        checks++; if (we_cnt - we0 !== 0) begin errors++; $display("FAIL prio_no_write got %0d want 0", we_cnt - we0); end
        readM = 1'b0;
        tick();
        dp_data = 16'hC0DE;
        dp_drive = 1'b1;
        lat = 1;
        while (!ackOutput && lat < 40) begin tick(); lat++; end
        checks++; if (ackOutput !== 1'b1 || lat != 5) begin errors++; $display("FAIL prio_write_ack got ack=%h lat=%0d want 1/5", ackOutput, lat); end
        writeM = 1'b0;
        tick();
        checks++; if (mem_a[8'h03] !== 16'hC0DE || we_cnt - we0 !== 1) begin
            errors++; $display("FAIL prio_write_mem got %h we=%0d want c0de/1", mem_a[8'h03], we_cnt - we0); end
    endtask

    task automatic test_reset_mid();
        int en0;
        en0 = en_cnt;
        address = 16'h0020;
        dp_data = 16'hDEAD;
        dp_drive = 1'b1;
        writeM = 1'b1;                      // cycle 0
        tick();                             // cycle 1: WAIT
        reset = 1'b1;
        writeM = 1'b0;
        tick();                             // cycle 2
        checks++; if (sram_en !== 1'b0 || ackOutput !== 1'b0 || inputReady !== 1'b0 || sram_we !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctrl got en=%h ack=%h ir=%h we=%h want 0", sram_en, ackOutput, inputReady, sram_we); end
        checks++; if (sram_addr !== 16'h0 || sram_wdata !== 16'h0) begin
            errors++; $display("FAIL rst_mid_bus got addr=%h wdata=%h want 0/0", sram_addr, sram_wdata); end
        tick();
        reset = 1'b0;
        repeat (6) tick();
        checks++; if (en_cnt - en0 !== 0 || mem_a[8'h20] !== 16'h1357) begin
            errors++; $display("FAIL rst_mid_dropped got strobes=%0d mem=%h want 0/1357", en_cnt - en0, mem_a[8'h20]); end
    endtask

    task automatic test_back_to_back();
        int en0, cyc;
        en0 = en_cnt_b;
        cyc = 0;
        address_b = 16'h0000;
        dp_drive_b = 1'b0;
        readM_b = 1'b1;                     // cycle 0
        do begin tick(); cyc++; end while (!inputReady_b && cyc < 40);
        checks++; if (inputReady_b !== 1'b1 || cyc != 3 || data_b !== 16'hA000) begin
            errors++; $display("FAIL b2b_first got ir=%h cyc=%0d data=%h want 1/3/a000", inputReady_b, cyc, data_b); end
        readM_b = 1'b0;
        tick(); cyc++;                      // cycle 4
        checks++; if (inputReady_b !== 1'b0) begin errors++; $display("FAIL b2b_release got %h want 0", inputReady_b); end
        tick(); cyc++;                      // cycle 5
        address_b = 16'h0001;
        readM_b = 1'b1;
        do begin tick(); cyc++; end while (!inputReady_b && cyc < 60);
        checks++; if (inputReady_b !== 1'b1 || cyc != 8 || data_b !== 16'hA001) begin
            errors++; $display("FAIL b2b_second got ir=%h cyc=%0d data=%h want 1/8/a001", inputReady_b, cyc, data_b); end
        readM_b = 1'b0;
        tick();
        dp_data_b = 16'h5A5A;
        dp_drive_b = 1'b1;
        #1;
        checks++; if (inputReady_b !== 1'b0 || data_b !== 16'h5A5A) begin
            errors++; $display("FAIL b2b_bus got ir=%h data=%h want 0/5a5a", inputReady_b, data_b); end
        checks++; if (en_cnt_b - en0 !== 2) begin errors++; $display("FAIL b2b_strobes got %0d want 2", en_cnt_b - en0); end
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats();
        int lat;
        bit to;
        logic [15:0] rd;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (rd_count !== 16'h0 || wr_count !== 16'h0) begin
            errors++; $display("FAIL stats_reset got rd=%h wr=%h want 0/0", rd_count, wr_count); end
        do_read(16'h0005, 16'h0, rd, lat, to);
        do_write(16'h0030, 16'h3030, lat, to);
        do_read(16'h0030, 16'h0, rd, lat, to);
        do_write(16'h0031, 16'h3131, lat, to);
        do_read(16'h0000, 16'h0, rd, lat, to);
        tick();
        checks++; if (rd_count !== 16'd3 || wr_count !== 16'd2) begin
            errors++; $display("FAIL stats_counts got rd=%0d wr=%0d want 3/2", rd_count, wr_count); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        readM = 1'b0; writeM = 1'b0; address = '0; dp_data = '0; dp_drive = 1'b1;
        readM_b = 1'b0; writeM_b = 1'b0; address_b = '0; dp_data_b = '0; dp_drive_b = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_val = '0;
        preload(8'h00, 16'hA000);
        preload(8'h01, 16'hA001);
        preload(8'h03, 16'h0333);
        preload(8'h05, 16'h7A12);
        preload(8'h20, 16'h1357);

        test_reset();
        test_read();
        test_write();
        test_read_priority();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_STATS_EN
        test_stats();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
